// File: rtl/i_cache_axi_rd_bridge_pkg.sv
// Shared AXI4 read-side encodings and the bridge's one-hot state codes.
// Contents: burst/size/resp/prot encodings, state_e, resp_is_err helper.
package i_cache_axi_rd_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
  localparam logic [2:0] AXI_PROT_INSTR  = 3'b100;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_AR   = 4'b0010,
    ST_R    = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

  // Slave or decode errors are the only failing response codes.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/i_cache_axi_rd_bridge_if.sv
// Bundle of the cache refill port and the AXI4 read channels (AR, R).
// master: bridge view (drives cache return and AR, consumes R).
// slave : environment view (cache + AXI slave).
interface i_cache_axi_rd_bridge_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
);
  logic              cache_read_ena;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_read_resp;
  logic [DATA_W-1:0] cache_in_data;
  logic              cache_in_valid;
  logic              arb_working_ti;
  logic              rd_err;

  logic              axi_ar_valid;
  logic              axi_ar_ready;
  logic [ADDR_W-1:0] axi_ar_addr;
  logic [ID_W-1:0]   axi_ar_id;
  logic [7:0]        axi_ar_len;
  logic [2:0]        axi_ar_size;
  logic [1:0]        axi_ar_burst;
  logic [2:0]        axi_ar_prot;

  logic              axi_r_valid;
  logic              axi_r_ready;
  logic [DATA_W-1:0] axi_r_data;
  logic [1:0]        axi_r_resp;
  logic              axi_r_last;
  logic [ID_W-1:0]   axi_r_id;

  modport master (
    input  cache_read_ena, cache_addr, cache_read_resp,
    output cache_in_data, cache_in_valid, arb_working_ti, rd_err,
    output axi_ar_valid, axi_ar_addr, axi_ar_id, axi_ar_len,
    output axi_ar_size, axi_ar_burst, axi_ar_prot,
    input  axi_ar_ready,
    input  axi_r_valid, axi_r_data, axi_r_resp, axi_r_last, axi_r_id,
    output axi_r_ready
  );

  modport slave (
    output cache_read_ena, cache_addr, cache_read_resp,
    input  cache_in_data, cache_in_valid, arb_working_ti, rd_err,
    input  axi_ar_valid, axi_ar_addr, axi_ar_id, axi_ar_len,
    input  axi_ar_size, axi_ar_burst, axi_ar_prot,
    output axi_ar_ready,
    output axi_r_valid, axi_r_data, axi_r_resp, axi_r_last, axi_r_id,
    input  axi_r_ready
  );
endinterface

// File: rtl/i_cache_axi_rd_bridge.sv
// Instruction-cache refill bridge: turns one cache line-fill request into a
// single-beat AXI4 read and holds the returned word until the cache accepts it.
// Ports: clk, rst (async, active-high), bus (i_cache_axi_rd_bridge_if.master).
module i_cache_axi_rd_bridge
  import i_cache_axi_rd_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned AXI_ID = 0
) (
  input logic                      clk,
  input logic                      rst,
  i_cache_axi_rd_bridge_if.master  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              drain_q;   // first beat taken without RLAST; discarding the rest
  logic              r_beat;
  logic              id_ok;

  assign r_beat = (state_q == ST_R) && bus.axi_r_valid;
  assign id_ok  = (bus.axi_r_id == ID_W'(AXI_ID));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.cache_read_ena)  state_d = ST_AR;
      ST_AR:   if (bus.axi_ar_ready)    state_d = ST_R;
      ST_R:    if (r_beat && bus.axi_r_last && (drain_q || id_ok)) state_d = ST_DONE;
      ST_DONE: if (bus.cache_read_resp) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address latch, data capture and sticky error tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && bus.cache_read_ena) begin
        addr_q <= bus.cache_addr & ~ADDR_W'(7);
      end
      if (r_beat) begin
        if (drain_q) begin
          if (!id_ok)         err_q   <= 1'b1;
          if (bus.axi_r_last) drain_q <= 1'b0;
        end else if (id_ok) begin
          data_q  <= bus.axi_r_data;
          drain_q <= !bus.axi_r_last;
          if (resp_is_err(bus.axi_r_resp) || !bus.axi_r_last) err_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Outputs decode straight from one-hot state flops and holding registers.
  always_comb begin
    bus.axi_ar_valid   = (state_q == ST_AR);
    bus.axi_r_ready    = (state_q == ST_R);
    bus.cache_in_valid = (state_q == ST_DONE);
    bus.arb_working_ti = (state_q != ST_IDLE);
    bus.axi_ar_addr    = addr_q;
    bus.cache_in_data  = data_q;
    bus.rd_err         = err_q;
    bus.axi_ar_id      = ID_W'(AXI_ID);
    bus.axi_ar_len     = 8'd0;
    bus.axi_ar_size    = AXI_SIZE_8B;
    bus.axi_ar_burst   = AXI_BURST_INCR;
    bus.axi_ar_prot    = AXI_PROT_INSTR;
  end

endmodule

// File: tb/tb_i_cache_axi_rd_bridge.sv
// Self-checking bench for i_cache_axi_rd_bridge: directed fetches plus a
// transaction-progress model compared against the DUT on every falling edge.
module tb_i_cache_axi_rd_bridge;
  import i_cache_axi_rd_bridge_pkg::*;

  localparam logic [3:0] TB_ID = 4'd0;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  i_cache_axi_rd_bridge_if #(.ADDR_W(64), .DATA_W(64), .ID_W(4)) bus ();

  i_cache_axi_rd_bridge #(.ADDR_W(64), .DATA_W(64), .ID_W(4), .AXI_ID(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: progress flags of the single outstanding fetch.
  logic        m_pend, m_ar_done, m_first, m_data_done, m_err;
  logic [63:0] m_addr, m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0; m_ar_done <= 1'b0; m_first <= 1'b0; m_data_done <= 1'b0;
      m_err  <= 1'b0; m_addr <= '0; m_data <= '0;
    end else if (!m_pend) begin
      if (bus.cache_read_ena) begin
        m_pend <= 1'b1;
        m_addr <= {bus.cache_addr[63:3], 3'b000};
      end
    end else if (!m_ar_done) begin
      if (bus.axi_ar_ready) m_ar_done <= 1'b1;
    end else if (!m_data_done) begin
      if (bus.axi_r_valid) begin
        if (bus.axi_r_id != TB_ID) m_err <= 1'b1;
        if (!m_first) begin
          if (bus.axi_r_id == TB_ID) begin
            m_first <= 1'b1;
            m_data  <= bus.axi_r_data;
            if (bus.axi_r_resp[1] || !bus.axi_r_last) m_err <= 1'b1;
            if (bus.axi_r_last) m_data_done <= 1'b1;
          end
        end else if (bus.axi_r_last) begin
          m_data_done <= 1'b1;
        end
      end
    end else if (bus.cache_read_resp) begin
      m_pend <= 1'b0; m_ar_done <= 1'b0; m_first <= 1'b0; m_data_done <= 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ar_valid", 64'(bus.axi_ar_valid),   64'(m_pend && !m_ar_done));
    chk("r_ready",  64'(bus.axi_r_ready),    64'(m_ar_done && !m_data_done));
    chk("in_valid", 64'(bus.cache_in_valid), 64'(m_data_done));
    chk("busy",     64'(bus.arb_working_ti), 64'(m_pend));
    chk("rd_err",   64'(bus.rd_err),         64'(m_err));
    chk("ar_addr",  bus.axi_ar_addr,         m_addr);
    chk("in_data",  bus.cache_in_data,       m_data);
    chk("ar_id",    64'(bus.axi_ar_id),      64'd0);
    chk("ar_len",   64'(bus.axi_ar_len),     64'd0);
    chk("ar_size",  64'(bus.axi_ar_size),    64'd3);
    chk("ar_burst", 64'(bus.axi_ar_burst),   64'd1);
    chk("ar_prot",  64'(bus.axi_ar_prot),    64'd4);
  end

  // mode 0: single good beat; 1: RLAST missing on beat 1; 2: wrong-ID beat first.
  task automatic fetch(input logic [63:0] addr, input logic [63:0] exp_addr,
                       input logic [63:0] data, input logic [1:0] resp,
                       input int ar_stall, input int hold, input int mode);
    bus.cache_read_ena  = 1'b1;
    bus.cache_addr      = addr;
    bus.cache_read_resp = (hold == 0);
    bus.axi_ar_ready    = (ar_stall == 0);
    bus.axi_r_valid     = 1'b1;
    bus.axi_r_resp      = resp;
    if (mode == 2) begin
      bus.axi_r_data = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.axi_r_id   = 4'h5;
      bus.axi_r_last = 1'b1;
    end else begin
      bus.axi_r_data = data;
      bus.axi_r_id   = TB_ID;
      bus.axi_r_last = (mode == 0);
    end
    step();
    bus.cache_addr = 64'h1234;
    for (int i = 0; i < ar_stall; i++) begin
      chk("stall_ar_valid", 64'(bus.axi_ar_valid), 64'd1);
      chk("stall_ar_addr",  bus.axi_ar_addr,       exp_addr);
      step();
    end
    bus.axi_ar_ready = 1'b1;
    chk("lit_ar_valid", 64'(bus.axi_ar_valid), 64'd1);
    chk("lit_ar_addr",  bus.axi_ar_addr,       exp_addr);
    step();
    bus.axi_ar_ready = 1'b0;
    chk("lit_r_ready", 64'(bus.axi_r_ready), 64'd1);
    step();
    if (mode != 0) begin
      chk("extra_r_ready",  64'(bus.axi_r_ready),    64'd1);
      chk("extra_in_valid", 64'(bus.cache_in_valid), 64'd0);
      bus.axi_r_data = (mode == 1) ? 64'h0BAD : data;
      bus.axi_r_id   = TB_ID;
      bus.axi_r_last = 1'b1;
      step();
    end
    bus.axi_r_valid    = 1'b0;
    bus.cache_read_ena = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_valid", 64'(bus.cache_in_valid), 64'd1);
      chk("hold_in_data",  bus.cache_in_data,       data);
      chk("hold_r_ready",  64'(bus.axi_r_ready),    64'd0);
      step();
    end
    bus.cache_read_resp = 1'b1;
    chk("lit_in_valid", 64'(bus.cache_in_valid), 64'd1);
    chk("lit_in_data",  bus.cache_in_data,       data);
    step();
    bus.cache_read_resp = 1'b0;
    chk("lit_in_valid_drop", 64'(bus.cache_in_valid), 64'd0);
    chk("lit_busy_idle",     64'(bus.arb_working_ti), 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.cache_read_ena = 1'b0; bus.cache_addr = '0; bus.cache_read_resp = 1'b0;
    bus.axi_ar_ready = 1'b0; bus.axi_r_valid = 1'b0; bus.axi_r_data = '0;
    bus.axi_r_resp = AXI_RESP_OKAY; bus.axi_r_last = 1'b0; bus.axi_r_id = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();
    chk("rst_in_valid", 64'(bus.cache_in_valid), 64'd0);
    chk("rst_ar_valid", 64'(bus.axi_ar_valid),   64'd0);
    chk("rst_busy",     64'(bus.arb_working_ti), 64'd0);
    chk("rst_rd_err",   64'(bus.rd_err),         64'd0);
    chk("rst_ar_addr",  bus.axi_ar_addr,         64'd0);
    chk("rst_in_data",  bus.cache_in_data,       64'd0);

    fetch(64'h8000_0004, 64'h8000_0000, 64'h0000_0013_0000_0093, AXI_RESP_OKAY, 0, 0, 0);
    chk("basic_rd_err", 64'(bus.rd_err), 64'd0);
    fetch(64'h8000_0004, 64'h8000_0000, 64'h1111_2222_3333_4444, AXI_RESP_OKAY, 5, 0, 0);
    fetch(64'h0000_2000, 64'h0000_2000, 64'hCAFE_F00D_0000_0001, AXI_RESP_OKAY, 0, 4, 0);
    chk("bp_rd_err", 64'(bus.rd_err), 64'd0);
    fetch(64'h9000_0010, 64'h9000_0010, 64'h0000_0000_0000_DEAD, AXI_RESP_SLVERR, 0, 0, 0);
    chk("slverr_rd_err", 64'(bus.rd_err), 64'd1);
    fetch(64'h9000_001F, 64'h9000_0018, 64'h5555_0000_5555_0000, AXI_RESP_OKAY, 1, 1, 0);
    chk("sticky_rd_err", 64'(bus.rd_err), 64'd1);

    // Asynchronous reset while waiting in R.
    bus.cache_read_ena = 1'b1; bus.cache_addr = 64'h8000_0040;
    bus.axi_ar_ready = 1'b1; bus.axi_r_valid = 1'b0;
    step();
    step();
    chk("mid_r_ready", 64'(bus.axi_r_ready), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ar_valid", 64'(bus.axi_ar_valid),   64'd0);
    chk("arst_r_ready",  64'(bus.axi_r_ready),    64'd0);
    chk("arst_in_valid", 64'(bus.cache_in_valid), 64'd0);
    chk("arst_busy",     64'(bus.arb_working_ti), 64'd0);
    chk("arst_rd_err",   64'(bus.rd_err),         64'd0);
    bus.cache_read_ena = 1'b0; bus.axi_ar_ready = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    fetch(64'h8000_0008, 64'h8000_0008, 64'h0000_0000_0000_7777, AXI_RESP_OKAY, 0, 0, 0);
    chk("post_rst_rd_err", 64'(bus.rd_err), 64'd0);

    fetch(64'h8000_010C, 64'h8000_0108, 64'h0123_4567_89AB_CDEF, AXI_RESP_OKAY, 0, 0, 1);
    chk("fault_rd_err", 64'(bus.rd_err), 64'd1);

    pulse_reset();
    chk("clr_rd_err", 64'(bus.rd_err), 64'd0);
    fetch(64'h0000_0040, 64'h0000_0040, 64'h0000_0000_0000_ABCD, AXI_RESP_OKAY, 0, 0, 2);
    chk("badid_rd_err", 64'(bus.rd_err), 64'd1);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
